// File: rtl/spi_test_pkg.sv
// Shared types and constants for the SPI link-test slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic SPI_MODE0 = 1'b0;
  localparam logic SPI_MODE3 = 1'b1;

  localparam int   DEFAULT_NUM_BYTES = 64;
  localparam logic MISO_IDLE         = 1'b1;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer plus edge detector for one asynchronous SPI pin.
// Latency: STAGES clk to level, edges flagged combinationally off the last stage.
// Backpressure: none; the pin is sampled every clk.
module spi_pin_sync
  import spi_test_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_val,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the pin through the synchronizer chain and keep one extra delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{idle_val}};
      dly_q  <= idle_val;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~dly_q;
  assign fall  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_checker.sv
// SPI slave that checks received bytes against 0,1,2,.. and drives pattern (or echo, SPI_SLAVE_ECHO_EN) on MISO.
// Latency: SYNC_STAGES+1..+2 clk from last SCK rise to rx_valid, depending on pin-to-clk phase.
// Backpressure: none; the master owns the clock, edges are processed as they arrive (spi_clk <= clk/8).
module spi_slave_checker
  import spi_test_pkg::*;
#(
  parameter int NUM_BYTES   = DEFAULT_NUM_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       mode_select,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] byte_count,
  output logic [7:0] match_count,
  output logic       pattern_err,
  output logic       receive_status
);

  localparam logic [7:0] NB_FULL = 8'(NUM_BYTES);
  localparam logic [7:0] NB_LAST = 8'(NUM_BYTES - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte_nxt;
  logic [7:0] tx_shift;
  logic [7:0] tx_byte;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_val (1'b1),
    .pin      (spi_cs_n),
    .level    (cs_s),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // SCK idles at the level implied by the selected mode, so reset there to avoid a phantom edge.
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_val (mode_select),
    .pin      (spi_clk),
    .level    (sck_s),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_val (1'b0),
    .pin      (spi_mosi),
    .level    (mosi_s),
    .rise     (mosi_rise),
    .fall     (mosi_fall)
  );

  // Only the SCK edges and the MOSI level carry meaning; the rest is folded away here.
  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

  assign rx_byte_nxt = {rx_shift, mosi_s};

`ifdef SPI_SLAVE_ECHO_EN
  // Loopback: return the previous received byte, all-ones before anything has arrived.
  assign tx_byte = (byte_count == 8'd0) ? 8'hFF : rx_data;
`else
  // Pattern: the index of the byte currently being exchanged.
  assign tx_byte = byte_count;
`endif

  // Link FSM plus receive datapath: shift on SCK rise, check and count each complete byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      rx_shift       <= 7'd0;
      rx_data        <= 8'd0;
      rx_valid       <= 1'b0;
      byte_count     <= 8'd0;
      match_count    <= 8'd0;
      pattern_err    <= 1'b0;
      receive_status <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (match_count == NB_FULL) begin
        receive_status <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Deselect mid-byte throws the partial byte away without touching the counts.
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
          end else if (sck_rise && !cs_s) begin
            rx_shift <= rx_byte_nxt[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data    <= rx_byte_nxt;
              rx_valid   <= 1'b1;
              byte_count <= byte_count + 8'd1;
              if (rx_byte_nxt == byte_count) begin
                match_count <= match_count + 8'd1;
              end else begin
                pattern_err <= 1'b1;
              end
              if (byte_count == NB_LAST) begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          // Run complete: hold everything until reset.
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transmit shifter: load at byte start, shift on SCK fall; mode 3 waits for the first fall to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= 8'd0;
    end else if (state == IDLE && cs_fall) begin
      tx_shift <= (mode_select == SPI_MODE0) ? tx_byte : {8{MISO_IDLE}};
    end else if (state == ACTIVE && !cs_rise && sck_fall) begin
      tx_shift <= (bit_cnt == 3'd0) ? tx_byte : {tx_shift[6:0], MISO_IDLE};
    end
  end

  assign spi_miso = (state == ACTIVE) ? tx_shift[7] : MISO_IDLE;

endmodule

// File: tb/tb_spi_slave_checker.sv
module tb_spi_slave_checker;

  localparam int NB   = 64;
  localparam int SS   = 2;
  localparam int HALF = 4;   // SCK half period in clk cycles (SCK = clk/8)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       mode_select;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] byte_count;
  logic [7:0] match_count;
  logic       pattern_err;
  logic       receive_status;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       cur_mode;

  always #5 clk = ~clk;

  spi_slave_checker #(.NUM_BYTES(NB), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_cs_n       (spi_cs_n),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .mode_select    (mode_select),
    .spi_miso       (spi_miso),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .byte_count     (byte_count),
    .match_count    (match_count),
    .pattern_err    (pattern_err),
    .receive_status (receive_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest byte the master fully sent.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL rx_unexpected: observed rx_valid with data %0h expected no pulse", rx_data);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert (rx_data === e) else begin
          miscompares++;
          $error("FAIL rx_data: observed %0h expected %0h", rx_data, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: observed simulation still running expected completion");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_miso(input int idx, input logic [7:0] prev);
`ifdef SPI_SLAVE_ECHO_EN
    return (idx == 0) ? 8'hFF : prev;
`else
    return 8'(idx);
`endif
  endfunction

  task automatic do_reset(input logic mode);
    rst_n       = 1'b0;
    cur_mode    = mode;
    mode_select = mode;
    spi_cs_n    = 1'b1;
    spi_clk     = mode;
    spi_mosi    = 1'b0;
    exp_q.delete();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (cur_mode == 1'b0) begin
        spi_mosi = mo[7-i];
        wait_clk(HALF);
        spi_clk = 1'b1;
        mi[7-i] = spi_miso;
        wait_clk(HALF);
        spi_clk = 1'b0;
      end else begin
        spi_clk  = 1'b0;
        spi_mosi = mo[7-i];
        wait_clk(HALF);
        spi_clk = 1'b1;
        mi[7-i] = spi_miso;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] em, input bit expect_rx, input string tag);
    logic [7:0] mi;
    if (expect_rx) exp_q.push_back(b);
    xfer(b, 8, mi);
    chk(tag, mi, em);
  endtask

  // One full run in a single frame; bad_idx (if in range) is sent as 0xFF.
  task automatic run_full(input int bad_idx, input string tag);
    logic [7:0] prev;
    logic [7:0] b;
    prev = 8'hFF;
    frame_begin();
    for (int i = 0; i < NB; i++) begin
      b = (i == bad_idx) ? 8'hFF : 8'(i);
      send_byte(b, exp_miso(i, prev), 1'b1, $sformatf("%s_miso%0d", tag, i));
      if (i == bad_idx - 1) chk({tag, "_err_before"}, pattern_err, 1'b0);
      if (i == bad_idx)     chk({tag, "_err_after"},  pattern_err, 1'b1);
      prev = b;
    end
    frame_end();
    chk({tag, "_rx_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] prev;

    // Reset state, mode 0
    do_reset(1'b0);
    chk("rst_miso",   spi_miso, 1'b1);
    chk("rst_rxdata", rx_data, 8'h00);
    chk("rst_rxvld",  rx_valid, 1'b0);
    chk("rst_bcnt",   byte_count, 8'd0);
    chk("rst_mcnt",   match_count, 8'd0);
    chk("rst_err",    pattern_err, 1'b0);
    chk("rst_status", receive_status, 1'b0);

    // Mode 0 full passing run
    run_full(-1, "m0");
    chk("m0_bcnt",   byte_count, 8'd64);
    chk("m0_mcnt",   match_count, 8'd64);
    chk("m0_status", receive_status, 1'b1);
    chk("m0_err",    pattern_err, 1'b0);

    // 65th byte after DONE: ignored, MISO held high
    frame_begin();
    send_byte(8'h40, 8'hFF, 1'b0, "done_miso");
    frame_end();
    chk("done_bcnt", byte_count, 8'd64);
    chk("done_mcnt", match_count, 8'd64);
    chk("done_miso_idle", spi_miso, 1'b1);

    // Mode 3 full passing run
    do_reset(1'b1);
    run_full(-1, "m3");
    chk("m3_bcnt",   byte_count, 8'd64);
    chk("m3_mcnt",   match_count, 8'd64);
    chk("m3_status", receive_status, 1'b1);
    chk("m3_err",    pattern_err, 1'b0);

    // Byte 5 corrupted
    do_reset(1'b0);
    run_full(5, "bad");
    chk("bad_bcnt",   byte_count, 8'd64);
    chk("bad_mcnt",   match_count, 8'd63);
    chk("bad_status", receive_status, 1'b0);
    chk("bad_err",    pattern_err, 1'b1);

    // Partial byte then deselect, then a full byte 0x00
    do_reset(1'b0);
    frame_begin();
    xfer(8'h00, 3, mi);
    frame_end();
    chk("part_bcnt", byte_count, 8'd0);
    frame_begin();
    send_byte(8'h00, exp_miso(0, 8'hFF), 1'b1, "part_miso");
    frame_end();
    chk("part_rx_pending", exp_q.size(), 0);
    chk("part_bcnt2", byte_count, 8'd1);
    chk("part_mcnt2", match_count, 8'd1);

    // Reset in the middle of byte 10, then a complete fresh run
    do_reset(1'b0);
    prev = 8'hFF;
    frame_begin();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i), exp_miso(i, prev), 1'b1, $sformatf("pre_miso%0d", i));
      prev = 8'(i);
    end
    xfer(8'h0A, 4, mi);
    chk("pre_rx_pending", exp_q.size(), 0);
    chk("pre_bcnt", byte_count, 8'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst_bcnt", byte_count, 8'd0);
    chk("midrst_mcnt", match_count, 8'd0);
    chk("midrst_miso", spi_miso, 1'b1);
    do_reset(1'b0);
    run_full(-1, "rerun");
    chk("rerun_bcnt",   byte_count, 8'd64);
    chk("rerun_status", receive_status, 1'b1);
    chk("rerun_err",    pattern_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
